// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline types and constants
package pipe_pkg;

    // Canonical no-op (addi x0, x0, 0) shown by empty stages.
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    // Widths of the packet carried between pipeline stages.
    localparam int PKT_XLEN = 32;
    localparam int PKT_ILEN = 32;

    // Skid occupancy, encoded as {skid.valid, main.valid}.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } skid_state_e;

    // Fetched instruction packet.
    typedef struct packed {
        logic                valid;
        logic [PKT_XLEN-1:0] pc;
        logic [PKT_ILEN-1:0] instr;
    } fetch_pkt_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc, stick at all-ones, clear only on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ifid_skid.sv
// rtl/ifid_skid.sv - IF/ID stage with two-entry skid buffer and bubble counter
module ifid_skid
    import pipe_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              ILEN      = 32,
    parameter logic [ILEN-1:0] NOP_INSTR = ILEN'(NOP_INSTR_DEFAULT),
    parameter int              CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [ILEN-1:0]  in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [ILEN-1:0]  out_instr,
    output logic [CNT_W-1:0] bubble_cnt
);

    logic            main_valid;
    logic [XLEN-1:0] main_pc;
    logic [ILEN-1:0] main_instr;
    logic            skid_valid;
    logic [XLEN-1:0] skid_pc;
    logic [ILEN-1:0] skid_instr;

    skid_state_e state;
    logic        in_fire;
    logic        out_fire;

    // Occupancy state is simply the pair of valid bits; handshakes use only registered readiness.
    always_comb begin
        state    = skid_state_e'({skid_valid, main_valid});
        in_fire  = in_valid & in_ready;
        out_fire = main_valid & out_ready;
    end

    // Head/skid registers and registered in_ready; reset beats flush beats handshakes.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid <= 1'b0;
            main_pc    <= '0;
            main_instr <= NOP_INSTR;
            skid_valid <= 1'b0;
            skid_pc    <= '0;
            skid_instr <= NOP_INSTR;
            in_ready   <= 1'b1;
        end else if (flush) begin
            main_valid <= 1'b0;
            main_pc    <= '0;
            main_instr <= NOP_INSTR;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_valid <= 1'b1;
                        main_pc    <= in_pc;
                        main_instr <= in_instr;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_pc    <= in_pc;
                        main_instr <= in_instr;
                    end else if (in_fire) begin
                        skid_valid <= 1'b1;
                        skid_pc    <= in_pc;
                        skid_instr <= in_instr;
                        in_ready   <= 1'b0;
                    end else if (out_fire) begin
                        main_valid <= 1'b0;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the drain side can move.
                    if (out_fire) begin
                        main_pc    <= skid_pc;
                        main_instr <= skid_instr;
                        skid_valid <= 1'b0;
                        in_ready   <= 1'b1;
                    end
                end
                default: begin
                    // Skid-without-head is unreachable; recover to empty.
                    main_valid <= 1'b0;
                    skid_valid <= 1'b0;
                    in_ready   <= 1'b1;
                end
            endcase
        end
    end

    // Decode side sees the head, or a NOP at pc 0 when nothing is held.
    always_comb begin
        out_valid = main_valid;
        out_pc    = main_valid ? main_pc : '0;
        out_instr = main_valid ? main_instr : NOP_INSTR;
    end

    sat_counter #(
        .W(CNT_W)
    ) u_bubble_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (~main_valid),
        .count(bubble_cnt)
    );

endmodule

// File: tb/tb_ifid_skid.sv
// tb/tb_ifid_skid.sv - randomized bench for ifid_skid against a queue model
module tb_ifid_skid;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_pc, in_instr;
    logic        in_ready, out_valid;
    logic [31:0] out_pc, out_instr;
    logic [15:0] bubble_cnt;

    logic        s_in_ready, s_out_valid;
    logic [31:0] s_out_pc, s_out_instr;
    logic [3:0]  s_bubble_cnt;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t q[$];
    bit   m_ready;
    int   m_bub;
    int   m_bub4;

    always #5 clk = ~clk;

    ifid_skid #(.XLEN(32), .ILEN(32), .NOP_INSTR(32'h0000_0013), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .bubble_cnt(bubble_cnt)
    );

    ifid_skid #(.XLEN(32), .ILEN(32), .NOP_INSTR(32'h0000_0013), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_pc(s_out_pc), .out_instr(s_out_instr),
        .bubble_cnt(s_bubble_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus, advance the reference, then compare all outputs.
    task automatic cycle(input bit r, input bit f, input bit iv, input logic [31:0] pc,
                         input logic [31:0] instr, input bit ordy);
        bit   inf, outf;
        ent_t e;
        reset = r; flush = f; in_valid = iv; in_pc = pc; in_instr = instr; out_ready = ordy;
        @(posedge clk);
        if (r) begin
            q.delete();
            m_ready = 1'b1;
            m_bub   = 0;
            m_bub4  = 0;
        end else begin
            if (q.size() == 0) begin
                if (m_bub < 65535) m_bub++;
                if (m_bub4 < 15) m_bub4++;
            end
            inf  = iv && m_ready;
            outf = (q.size() > 0) && ordy;
            if (f) begin
                q.delete();
                m_ready = 1'b1;
            end else begin
                if (outf) q.delete(0);
                if (inf) begin
                    e.pc = pc;
                    e.instr = instr;
                    q.push_back(e);
                end
                m_ready = (q.size() < 2);
            end
        end
        #1;
        check("in_ready",  {31'd0, in_ready},  {31'd0, m_ready});
        check("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
        check("out_pc",    out_pc,    (q.size() > 0) ? q[0].pc : 32'd0);
        check("out_instr", out_instr, (q.size() > 0) ? q[0].instr : 32'h0000_0013);
        check("bubble_cnt",  {16'd0, bubble_cnt},  m_bub);
        check("bubble_cnt4", {28'd0, s_bubble_cnt}, m_bub4);
        check("in_ready4",  {31'd0, s_in_ready},  {31'd0, m_ready});
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 32'd0, 32'd0, ordy);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; out_ready = 1'b0;

        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        check("reset_out_instr", out_instr, 32'h0000_0013);
        check("reset_bubble", {16'd0, bubble_cnt}, 32'd0);

        // Idle after reset: counter reaches 5.
        idle(5, 1);
        check("idle5_bubble", {16'd0, bubble_cnt}, 32'd5);
        check("idle5_ready", {31'd0, in_ready}, 32'd1);

        // Streaming at full rate.
        cycle(0, 0, 1, 32'h0, 32'hA, 1);
        check("stream_first_pc", out_pc, 32'h0);
        cycle(0, 0, 1, 32'h4, 32'hB, 1);
        cycle(0, 0, 1, 32'h8, 32'hC, 1);
        check("stream_last_instr", out_instr, 32'hC);
        idle(2, 1);

        // Backpressure into FULL, then drain.
        cycle(0, 0, 1, 32'h0, 32'h11, 0);
        cycle(0, 0, 1, 32'h4, 32'h22, 0);
        check("full_ready_low", {31'd0, in_ready}, 32'd0);
        cycle(0, 0, 1, 32'h8, 32'h33, 1);
        check("drain_ready_back", {31'd0, in_ready}, 32'd1);
        check("drain_second_pc", out_pc, 32'h4);
        idle(2, 1);

        // Flush while FULL with a new input offered.
        cycle(0, 0, 1, 32'h10, 32'h44, 0);
        cycle(0, 0, 1, 32'h14, 32'h55, 0);
        cycle(0, 1, 1, 32'h18, 32'h66, 0);
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_nop", out_instr, 32'h0000_0013);
        idle(3, 1);

        // Reset and flush together while holding one entry.
        cycle(0, 0, 1, 32'h20, 32'h77, 0);
        cycle(1, 1, 0, 32'h0, 32'h0, 0);
        check("rst_flush_bubble", {16'd0, bubble_cnt}, 32'd0);

        // Narrow counter saturates at 15.
        idle(20, 0);
        check("sat4_bubble", {28'd0, s_bubble_cnt}, 32'd15);

        // Randomized traffic with occasional flush and rare reset.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 29) == 0),
                  ($urandom_range(0, 3) != 0), $urandom, $urandom,
                  ($urandom_range(0, 2) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
